rtdf_sample_unpacker: RTL
=========================

# rtdf_sample_unpacker

Downstream consumer of the RTDF stream FIFO read port. Waits for a prefill depth, pops 16-bit payload words, restores network byte order and serialises them into 2-bit IF samples. Samples are released one per `enable` strobe to the correlator front end. Counts buffer underruns and recovers from them by re-prefilling.

## Interface
- `SAMPLE_WIDTH`, 2: bits per IF sample; must divide 16. Samples per word `SPW` = 16/SAMPLE_WIDTH.
- `PREFILL_WORDS`, 128: minimum FIFO read-side fill level before streaming starts or restarts; range 2..511.
- `clk` in 1: stream FIFO read clock; sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear back to prefill.
- `enable` in 1: sample pacing strobe, one per IF sample period; may be high on consecutive cycles.
- `fifo_empty` in 1: stream FIFO read-side empty.
- `fifo_data` in 16: stream FIFO q, normal (non-show-ahead) mode.
- `fifo_words` in 9: stream FIFO read-side used words.
- `fifo_read` out 1: FIFO read request.
- `sample_valid` out 1: `sample` is valid this cycle.
- `sample` out SAMPLE_WIDTH: IF sample, sign/magnitude passthrough.
- `running` out 1: high in RUN.
- `underrun_count` out 9: underrun events since reset; saturates at 511.

## Operation
- Buffer: `cur` word with sample index `idx` (0..SPW-1), plus `nxt` word with `nxt_valid`. At most one read is in flight.
- Fetch engine: if a slot is free, no read is in flight and `fifo_empty`=0, register `fifo_read`=1 for exactly one cycle. `fifo_data` is captured on the following cycle into `cur` during LOAD, otherwise into `nxt`.
- Word order: w = {fifo_data[7:0], fifo_data[15:8]}. Sample k = w[15-k·SAMPLE_WIDTH -: SAMPLE_WIDTH]; k=0 is emitted first.
- States, encoded in `RTDF_UNPACK_STATE_RANGE`:
  - PREFILL: buffers invalid and no reads. Move to LOAD when `fifo_words` ≥ PREFILL_WORDS.
  - LOAD: fetch `cur`, then `nxt`. Move to RUN the cycle after `nxt` is captured.
  - RUN: each `enable` emits sample `idx` of `cur` and increments `idx`.
    - At idx=SPW-1 with `nxt_valid`=1: `cur`←`nxt`, `idx`←0, `nxt_valid`←0, and a refill starts.
    - At idx=SPW-1 with `nxt_valid`=0 (underrun): the sample is still emitted, `underrun_count` increments, and the state goes to PREFILL with buffers cleared.
- `enable` outside RUN is ignored: no sample, no count.
- `flush`: from any state go to PREFILL. Clear `idx` and both valids. Discard any in-flight read data on the next cycle. `underrun_count` is not cleared.
- Priority: `reset_n` > `flush` > `enable`/fetch. Simultaneous `flush` and `enable` produce no sample.

## Timing
- Reset values: `fifo_read`=0, `sample_valid`=0, `sample`=0, `running`=0, `underrun_count`=0, state=PREFILL.
- Sample latency: `enable` at cycle n in RUN → `sample_valid`=1 with the sample at n+1, held for one cycle. `sample` holds its last value otherwise.
- Read latency: `fifo_read` high at n → data captured at n+1. The next `fifo_read` is no earlier than n+2.
- Refill after a word handoff at cycle n completes by n+2. SPW ≥ 2 covers back-to-back `enable` with no underrun while the FIFO is non-empty.
- `fifo_read` is never high when `fifo_empty` was high on the previous cycle. Only this block drains the FIFO, so a registered request is safe.
- PREFILL→LOAD: one cycle after the threshold is met. LOAD→RUN: 5 cycles with a non-empty FIFO.
- `running` is registered from the state and equals (state==RUN).

## Structure
- `rtdf_sample_unpacker.vh`: state encodings, `RTDF_UNPACK_STATE_RANGE`, default PREFILL_WORDS, and the counter width.
- One sub-module, `rtdf_word_fetch`: owns the `fifo_read` issue, in-flight flag, discard-on-flush and capture strobe. The top level owns state, `cur`/`nxt`, `idx` and the counters.

## Test plan
- Reset, then FIFO loaded with 4 words (PREFILL_WORDS=4), first word 0x1BE4 (w=0xE41B) → after LOAD, 8 enables yield samples 3,2,1,0,0,1,2,3; `running`=1.
- Back-to-back `enable` for 64 cycles with 16 words prefilled and the FIFO kept non-empty → 64 contiguous `sample_valid` pulses, `underrun_count`=0, `fifo_read` never adjacent-cycle.
- FIFO holds exactly PREFILL_WORDS=4 words, no refill, continuous `enable` → 32 samples, then underrun: `underrun_count`=1, `running`=0, state PREFILL. Refill to 4 words → restart.
- `flush` asserted the cycle after `fifo_read` in RUN → no `sample_valid` that cycle, captured word discarded, return to PREFILL, `underrun_count` unchanged.
- 600 forced underruns → `underrun_count` saturates at 511.
- `reset_n` deasserted mid-RUN, asynchronously → all outputs are at reset values immediately. After release, PREFILL waits for `fifo_words` ≥ PREFILL_WORDS.

Source files
------------

// File: rtl/rtdf_sample_unpacker_pkg.sv
// Shared definitions for the RTDF sample unpacker: state encoding, default
// prefill depth, counter widths and the network byte-order helper.
package rtdf_sample_unpacker_pkg;

    localparam int RTDF_UNPACK_STATE_W        = 2;
    localparam int RTDF_PREFILL_WORDS_DEFAULT = 128;
    localparam int RTDF_FIFO_CNT_W            = 9;
    localparam int RTDF_UNDERRUN_CNT_W        = 9;

    typedef enum logic [RTDF_UNPACK_STATE_W-1:0] {
        RTDF_ST_PREFILL = 2'd0,
        RTDF_ST_LOAD    = 2'd1,
        RTDF_ST_RUN     = 2'd2
    } rtdf_unpack_state_e;

    // Payload words arrive little-end first; swap bytes so sample 0 sits in the MSBs.
    function automatic logic [15:0] rtdf_net_order(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/rtdf_sample_unpacker_word_fetch.sv
// Read-request engine for the stream FIFO. Issues a single registered read
// when the owner has a free slot, tracks the in-flight word and raises a
// capture strobe on the cycle the FIFO q is valid. A flush drops both a
// pending request and any word already on its way.
module rtdf_word_fetch (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic slot_free,
    input  logic fifo_empty,
    output logic fifo_read,
    output logic capture
);

    logic read_q, read_d;
    logic pend_q, pend_d;

    // Next request and in-flight tracking; never two requests on adjacent cycles.
    always_comb begin
        read_d = slot_free & ~read_q & ~fifo_empty & ~flush;
        pend_d = read_q & ~flush;
    end

    // Request and in-flight registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            read_q <= read_d;
            pend_q <= pend_d;
        end
    end

    assign fifo_read = read_q;
    assign capture   = pend_q & ~flush;

endmodule

// File: rtl/rtdf_sample_unpacker.sv
// RTDF sample unpacker: prefills from the stream FIFO, keeps a current and a
// next payload word, and releases one IF sample per enable strobe. Underruns
// are counted (saturating) and recovered by re-prefilling.
//
// state   | meaning
// --------+---------------------------------------------------------------
// PREFILL | buffers empty, no reads; wait for FIFO fill >= PREFILL_WORDS
// LOAD    | fetch cur, then nxt; RUN the cycle after nxt lands
// RUN     | emit one sample per enable, hand nxt over to cur at word end
module rtdf_sample_unpacker
    import rtdf_sample_unpacker_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 2,
    parameter int PREFILL_WORDS = RTDF_PREFILL_WORDS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic                           enable,
    input  logic                           fifo_empty,
    input  logic [15:0]                    fifo_data,
    input  logic [RTDF_FIFO_CNT_W-1:0]     fifo_words,
    output logic                           fifo_read,
    output logic                           sample_valid,
    output logic [SAMPLE_WIDTH-1:0]        sample,
    output logic                           running,
    output logic [RTDF_UNDERRUN_CNT_W-1:0] underrun_count
);

    localparam int SPW   = 16 / SAMPLE_WIDTH;
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);
    localparam logic [RTDF_FIFO_CNT_W-1:0] PREFILL_THR = RTDF_FIFO_CNT_W'(PREFILL_WORDS);

    rtdf_unpack_state_e state_q, state_d;
    logic [15:0]             cur_q, cur_d;
    logic [15:0]             nxt_q, nxt_d;
    logic                    cur_v_q, cur_v_d;
    logic                    nxt_v_q, nxt_v_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    running_q;
    logic [RTDF_UNDERRUN_CNT_W-1:0] underrun_q, underrun_d;

    logic                    capture;
    logic                    slot_free;
    logic [15:0]             word_in;
    logic [15:0]             cur_shift;
    logic [SAMPLE_WIDTH-1:0] cur_sample;

    assign word_in = rtdf_net_order(fifo_data);

    // Select sample idx of cur by shifting it up to the MSBs.
    always_comb begin
        cur_shift = cur_q << (32'(idx_q) * SAMPLE_WIDTH);
    end

    assign cur_sample = cur_shift[15 -: SAMPLE_WIDTH];

    // Reads are requested against the post-update buffer view so a handoff
    // starts its refill on the very next cycle.
    assign slot_free = (state_q != RTDF_ST_PREFILL) && (state_d != RTDF_ST_PREFILL)
                       && !(cur_v_d && nxt_v_d);

    rtdf_word_fetch u_fetch (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .slot_free  (slot_free),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .capture    (capture)
    );

    // Next-state, buffer handoff, sample emission and underrun accounting.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        nxt_d          = nxt_q;
        cur_v_d        = cur_v_q;
        nxt_v_d        = nxt_v_q;
        idx_d          = idx_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        underrun_d     = underrun_q;

        if (flush) begin
            state_d = RTDF_ST_PREFILL;
            idx_d   = '0;
            cur_v_d = 1'b0;
            nxt_v_d = 1'b0;
        end else begin
            case (state_q)
                RTDF_ST_PREFILL: begin
                    cur_v_d = 1'b0;
                    nxt_v_d = 1'b0;
                    idx_d   = '0;
                    if (fifo_words >= PREFILL_THR) begin
                        state_d = RTDF_ST_LOAD;
                    end
                end
                RTDF_ST_LOAD: begin
                    if (capture) begin
                        if (!cur_v_q) begin
                            cur_d   = word_in;
                            cur_v_d = 1'b1;
                        end else begin
                            nxt_d   = word_in;
                            nxt_v_d = 1'b1;
                            state_d = RTDF_ST_RUN;
                        end
                    end
                end
                RTDF_ST_RUN: begin
                    if (capture) begin
                        nxt_d   = word_in;
                        nxt_v_d = 1'b1;
                    end
                    if (enable) begin
                        sample_valid_d = 1'b1;
                        sample_d       = cur_sample;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (nxt_v_q) begin
                                cur_d   = nxt_q;
                                nxt_v_d = 1'b0;
                            end else begin
                                // Last sample of the last buffered word: still emitted, then re-prefill.
                                if (underrun_q != '1) begin
                                    underrun_d = underrun_q + 1'b1;
                                end
                                state_d = RTDF_ST_PREFILL;
                                cur_v_d = 1'b0;
                                nxt_v_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = RTDF_ST_PREFILL;
                    cur_v_d = 1'b0;
                    nxt_v_d = 1'b0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State, buffers, output registers and the underrun counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RTDF_ST_PREFILL;
            cur_q          <= '0;
            nxt_q          <= '0;
            cur_v_q        <= 1'b0;
            nxt_v_q        <= 1'b0;
            idx_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            running_q      <= 1'b0;
            underrun_q     <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            nxt_q          <= nxt_d;
            cur_v_q        <= cur_v_d;
            nxt_v_q        <= nxt_v_d;
            idx_q          <= idx_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            running_q      <= (state_d == RTDF_ST_RUN);
            underrun_q     <= underrun_d;
        end
    end

    assign sample_valid   = sample_valid_q;
    assign sample         = sample_q;
    assign running        = running_q;
    assign underrun_count = underrun_q;

endmodule
